apb_master_nslave: RTL

//  Parametrised APB3 master bridge: accepts single read/write requests from the test/system side
//  and runs them on an APB bus shared by NUM_SLAVES slaves.

---
 rtl/apb_master_nslave_pkg.sv | 27 ++
 rtl/apb_master_nslave_addr_decoder.sv | 28 ++
 rtl/apb_master_nslave.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_nslave_pkg.sv
// apb_master_pkg: shared types for the APB master bridge.
//   apb_state_e : bridge FSM states (IDLE, SETUP, ACCESS)
//   sel_w()     : number of address MSBs used to select a slave
//   apb_req_t   : latched request {write, addr, wdata}, sized for the widest
//                 supported bus; the bridge uses the low AW/DW bits.
package apb_master_pkg;

    localparam int APB_MAX_AW = 32;
    localparam int APB_MAX_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic                  write;
        logic [APB_MAX_AW-1:0] addr;
        logic [APB_MAX_DW-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_nslave_addr_decoder.sv
// apb_addr_decoder: combinational slave decode from an APB address.
//   addr       in   AW          address; top SEL_W bits are the slave index
//   idx        out  SEL_W       slave index
//   sel_onehot out  NUM_SLAVES  one-hot select, all zero on decode error
//   dec_err    out  1           index does not name an existing slave
module apb_addr_decoder
    import apb_master_pkg::*;
#(
    parameter int AW         = 9,
    parameter int NUM_SLAVES = 2
) (
    input  logic [AW-1:0]                addr,
    output logic [sel_w(NUM_SLAVES)-1:0] idx,
    output logic [NUM_SLAVES-1:0]        sel_onehot,
    output logic                         dec_err
);
    localparam int SEL_W = sel_w(NUM_SLAVES);

    always_comb begin
        idx        = addr[AW-1 -: SEL_W];
        dec_err    = (int'(idx) >= NUM_SLAVES);
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(idx) == i) sel_onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_nslave.sv
// apb_master_nslave: APB3 master bridge for a bus shared by NUM_SLAVES slaves.
// Accepts single read/write requests, runs them as SETUP/ACCESS phases, and
// reports each completion with a one-cycle done pulse plus error status.
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   transfer, READ_WRITE          request strobe and direction (1 = write)
//   apb_read_paddr/write_paddr    request address (chosen by direction)
//   apb_write_data                write data
//   apb_read_data_out             last read data, held until the next read
//   done, error, timeout          completion pulse and its status
//   busy                          FSM not in IDLE
//   PSEL..PWDATA                  APB master outputs
//   PRDATA, PREADY, PSLVERR       per-slave APB responses
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES cycles without PREADY.
// Handshake: a request is accepted when transfer=1 is sampled in IDLE or in
// the ACCESS cycle where the selected slave's PREADY=1; at any other time
// transfer is ignored, never queued.
module apb_master_nslave
    import apb_master_pkg::*;
#(
    parameter int AW             = 9,
    parameter int DW             = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     transfer,
    input  logic                     READ_WRITE,
    input  logic [AW-1:0]            apb_read_paddr,
    input  logic [AW-1:0]            apb_write_paddr,
    input  logic [DW-1:0]            apb_write_data,
    output logic [DW-1:0]            apb_read_data_out,
    output logic                     done,
    output logic                     error,
    output logic                     timeout,
    output logic                     busy,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [AW-1:0]            PADDR,
    output logic [DW-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DW-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);
    localparam int SEL_W = sel_w(NUM_SLAVES);

    apb_state_e state_q, state_d;
    apb_req_t   req_q, req_d, new_req;
    logic [DW-1:0] rdata_q, rdata_d;
    logic done_q, done_d, error_q, error_d;

    logic [SEL_W-1:0]      cur_idx, new_idx;
    logic [NUM_SLAVES-1:0] cur_onehot, new_onehot;
    logic                  cur_err, new_err;
    logic [AW-1:0]         new_addr;
    logic                  sel_ready, sel_slverr, tmo_abort;
    logic [DW-1:0]         sel_rdata;

    assign new_addr = READ_WRITE ? apb_write_paddr : apb_read_paddr;

    // Decode of the latched request drives PSEL; decode of the incoming
    // request catches a bad address before any bus cycle is started.
    apb_addr_decoder #(.AW(AW), .NUM_SLAVES(NUM_SLAVES)) u_cur_dec (
        .addr(req_q.addr[AW-1:0]), .idx(cur_idx), .sel_onehot(cur_onehot), .dec_err(cur_err)
    );
    apb_addr_decoder #(.AW(AW), .NUM_SLAVES(NUM_SLAVES)) u_new_dec (
        .addr(new_addr), .idx(new_idx), .sel_onehot(new_onehot), .dec_err(new_err)
    );

    // Only the selected slave's response is looked at.
    always_comb begin
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(cur_idx) == i) begin
                sel_ready  = PREADY[i];
                sel_slverr = PSLVERR[i];
                sel_rdata  = PRDATA[i*DW +: DW];
            end
        end
    end

    always_comb begin
        new_req                = '0;
        new_req.write          = READ_WRITE;
        new_req.addr[AW-1:0]   = new_addr;
        new_req.wdata[DW-1:0]  = apb_write_data;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    req_d = new_req;
                    if (new_err) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                // Reached with a bad address only via a back-to-back request.
                if (cur_err) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    done_d  = 1'b1;
                    error_d = sel_slverr;
                    if (!req_q.write) rdata_d = sel_rdata;
                    if (transfer) begin
                        req_d   = new_req;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_abort) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;

    // Counts completed ACCESS cycles; cleared whenever the FSM leaves ACCESS.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ACCESS) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    assign tmo_abort = (state_q == ACCESS) && !sel_ready &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_d = tmo_abort;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_abort = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign apb_read_data_out = rdata_q;
    assign done              = done_q;
    assign error             = error_q;
    assign busy              = (state_q != IDLE);
    assign PSEL              = (state_q != IDLE && !cur_err) ? cur_onehot : '0;
    assign PENABLE           = (state_q == ACCESS);
    assign PWRITE            = req_q.write;
    assign PADDR             = req_q.addr[AW-1:0];
    assign PWDATA            = req_q.wdata[DW-1:0];

endmodule
